// File: rtl/ps2_kbd_fifo.sv
// Keyboard scancode FIFO between the PS/2 receiver and the CPU port bus.
// 8042-style data/status ports, level IRQ while data is pending, sticky overflow.
module ps2_kbd_fifo #(
    parameter int          DEPTH_LOG2 = 4,   // minimum 3: status reports count in 4 bits
    parameter logic [15:0] DATA_PORT  = 16'h0060,
    parameter logic [15:0] STAT_PORT  = 16'h0064
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  ps2_data,
    input  logic        ps2_data_clk,
    input  logic [15:0] port_addr,
    input  logic [7:0]  port_out,
    input  logic        port_clk,
    input  logic        port_read,
    output logic [7:0]  port_in,
    output logic        kbd_irq,
    output logic        overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    localparam logic [7:0] CMD_FLUSH   = 8'hFF;
    localparam logic [7:0] CMD_CLR_OVF = 8'hFE;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  kbd_irq_q, kbd_irq_d;
    logic [7:0]            port_in_q, port_in_d;

    // Edge detectors store the inverted strobe ("was low last cycle"). Reset
    // to 0 means "not seen low yet", so a strobe held high across reset
    // release cannot produce an event until it has dropped and risen again.
    logic ps2_low_q,  ps2_low_d;
    logic wclk_low_q, wclk_low_d;
    logic rd_low_q,   rd_low_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       ps2_ev, wr_ev, rd_ev;
    logic       full, empty;
    logic       cmd_ev, flush, clr_ovf;
    logic       pop_ok, push_ok, drop;
    logic       mem_we;
    logic [3:0] cnt4;
    logic [7:0] status;
    logic [7:0] head;

    always_comb begin
        ps2_low_d  = ~ps2_data_clk;
        wclk_low_d = ~port_clk;
        rd_low_d   = ~port_read;

        ps2_ev = ps2_data_clk & ps2_low_q;
        wr_ev  = port_clk     & wclk_low_q;
        rd_ev  = port_read    & rd_low_q;

        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);

        cmd_ev  = wr_ev && (port_addr == STAT_PORT);
        flush   = cmd_ev && (port_out == CMD_FLUSH);
        clr_ovf = cmd_ev && (port_out == CMD_CLR_OVF);

        // A pop in the same cycle frees the slot the push needs when full.
        pop_ok  = rd_ev && (port_addr == DATA_PORT) && !empty;
        push_ok = ps2_ev && (!full || pop_ok);
        drop    = ps2_ev && full && !pop_ok;

        mem_we  = push_ok && !flush;
    end

    // ------------------------------------------------------------------
    // Pointer / count / flag next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A fresh drop outranks a clear-overflow command in the same cycle.
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        // Flush wins over everything, including a same-cycle push or drop.
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end

        kbd_irq_d = (count_d != '0);
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        head   = mem_q[rd_ptr_q];
        cnt4   = (count_q > CNT_W'(15)) ? 4'hF : count_q[3:0];
        status = {cnt4, 1'b0, overflow_q, full, ~empty};

        port_in_d = 8'h00;
        if (port_addr == DATA_PORT) begin
            port_in_d = empty ? 8'h00 : head;
        end else if (port_addr == STAT_PORT) begin
            port_in_d = status;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            kbd_irq_q  <= 1'b0;
            port_in_q  <= 8'h00;
            ps2_low_q  <= 1'b0;
            wclk_low_q <= 1'b0;
            rd_low_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            kbd_irq_q  <= kbd_irq_d;
            port_in_q  <= port_in_d;
            ps2_low_q  <= ps2_low_d;
            wclk_low_q <= wclk_low_d;
            rd_low_q   <= rd_low_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= ps2_data;
        end
    end

    assign port_in  = port_in_q;
    assign kbd_irq  = kbd_irq_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Self-checking bench for ps2_kbd_fifo: scoreboard queue of pushed scancodes
// plus a small count/overflow model used to predict the status port.
module tb_ps2_kbd_fifo;

    localparam logic [15:0] DATA_PORT = 16'h0060;
    localparam logic [15:0] STAT_PORT = 16'h0064;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  ps2_data;
    logic        ps2_data_clk;
    logic [15:0] port_addr;
    logic [7:0]  port_out;
    logic        port_clk;
    logic        port_read;
    logic [7:0]  port_in;
    logic        kbd_irq;
    logic        overflow;

    ps2_kbd_fifo #(
        .DEPTH_LOG2 (4),
        .DATA_PORT  (DATA_PORT),
        .STAT_PORT  (STAT_PORT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_data     (ps2_data),
        .ps2_data_clk (ps2_data_clk),
        .port_addr    (port_addr),
        .port_out     (port_out),
        .port_clk     (port_clk),
        .port_read    (port_read),
        .port_in      (port_in),
        .kbd_irq      (kbd_irq),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int         m_cnt;
    logic       m_ovf;
    int         n_pass;
    int         n_total;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] exp_stat();
        logic [3:0] c4;
        c4 = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
        return {c4, 1'b0, m_ovf, (m_cnt == 16), (m_cnt != 0)};
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (m_cnt == 16) begin
            m_ovf = 1'b1;
        end else begin
            exp_q.push_back(b);
            m_cnt++;
        end
    endfunction

    function automatic logic [7:0] model_pop();
        logic [7:0] v;
        v = 8'h00;
        if (m_cnt != 0) begin
            v = exp_q.pop_front();
            m_cnt--;
        end
        return v;
    endfunction

    task automatic push_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        ps2_data     = b;
        ps2_data_clk = 1'b1;
        repeat (hold) @(negedge clk);
        ps2_data_clk = 1'b0;
        model_push(b);
    endtask

    task automatic pop_byte(input string tag);
        @(negedge clk);
        port_addr = DATA_PORT;
        port_read = 1'b1;
        @(negedge clk);
        port_read = 1'b0;
        chk(tag, {8'h00, port_in}, {8'h00, model_pop()});
    endtask

    task automatic check_stat(input string tag);
        @(negedge clk);
        port_addr = STAT_PORT;
        @(negedge clk);
        chk(tag, {8'h00, port_in}, {8'h00, exp_stat()});
    endtask

    task automatic wr_cmd(input logic [15:0] addr, input logic [7:0] v);
        @(negedge clk);
        port_addr = addr;
        port_out  = v;
        port_clk  = 1'b1;
        @(negedge clk);
        port_clk  = 1'b0;
        if (addr == STAT_PORT && v == 8'hFF) model_clear();
        if (addr == STAT_PORT && v == 8'hFE) m_ovf = 1'b0;
    endtask

    // Push and pop rising on the same edge; the popped byte is the pre-push head.
    task automatic push_pop(input logic [7:0] b, input string tag);
        logic [7:0] e;
        @(negedge clk);
        ps2_data     = b;
        ps2_data_clk = 1'b1;
        port_addr    = DATA_PORT;
        port_read    = 1'b1;
        @(negedge clk);
        ps2_data_clk = 1'b0;
        port_read    = 1'b0;
        e = model_pop();
        model_push(b);
        chk(tag, {8'h00, port_in}, {8'h00, e});
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        model_clear();
        reset_n      = 1'b0;
        ps2_data     = 8'h00;
        ps2_data_clk = 1'b0;
        port_addr    = 16'h0000;
        port_out     = 8'h00;
        port_clk     = 1'b0;
        port_read    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_port_in", {8'h00, port_in}, 16'h0000);
        chk("rst_irq", {15'h0, kbd_irq}, 16'h0000);
        chk("rst_ovf", {15'h0, overflow}, 16'h0000);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single push with a 3-cycle strobe
        @(negedge clk);
        ps2_data     = 8'h1C;
        ps2_data_clk = 1'b1;
        @(negedge clk);
        chk("irq_rise", {15'h0, kbd_irq}, 16'h0001);
        repeat (2) @(negedge clk);
        ps2_data_clk = 1'b0;
        model_push(8'h1C);
        check_stat("stat_one");
        chk("stat_one_const", {8'h00, port_in}, 16'h0011);
        pop_byte("pop_1c");
        chk("irq_fall", {15'h0, kbd_irq}, 16'h0000);
        check_stat("stat_empty");

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
        push_byte(8'hAA, 2);
        check_stat("stat_full_ovf");
        chk("stat_f7", {8'h00, port_in}, 16'h00F7);
        for (int i = 0; i < 16; i++) pop_byte("drain");
        pop_byte("pop_empty_no_aa");
        chk("ovf_sticky", {15'h0, overflow}, 16'h0001);
        wr_cmd(DATA_PORT, 8'hFE);
        chk("ovf_data_wr_ignored", {15'h0, overflow}, 16'h0001);
        wr_cmd(STAT_PORT, 8'h12);
        chk("ovf_other_cmd", {15'h0, overflow}, 16'h0001);
        wr_cmd(STAT_PORT, 8'hFE);
        chk("ovf_cleared", {15'h0, overflow}, 16'h0000);
        check_stat("stat_after_clr");

        // Wrap-around
        for (int i = 0; i < 10; i++) push_byte(8'h30 + 8'(i), 1);
        for (int i = 0; i < 10; i++) pop_byte("wrap_a");
        for (int i = 0; i < 12; i++) push_byte(8'h80 + 8'(i * 3), 1);
        for (int i = 0; i < 12; i++) pop_byte("wrap_b");
        check_stat("stat_wrap_empty");

        // Simultaneous push/pop: empty, count 3, full
        push_pop(8'h41, "pp_empty");
        check_stat("stat_pp_empty");
        push_byte(8'h42, 1);
        push_byte(8'h43, 1);
        push_pop(8'h44, "pp_three");
        check_stat("stat_pp_three");
        for (int i = 0; i < 3; i++) pop_byte("pp_drain3");
        for (int i = 0; i < 16; i++) push_byte(8'hC0 + 8'(i), 1);
        push_pop(8'hE5, "pp_full");
        check_stat("stat_pp_full");
        chk("pp_full_no_ovf", {15'h0, overflow}, 16'h0000);
        for (int i = 0; i < 16; i++) pop_byte("pp_drain16");

        // Flush with a same-cycle push
        for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i), 1);
        @(negedge clk);
        port_addr    = STAT_PORT;
        port_out     = 8'hFF;
        port_clk     = 1'b1;
        ps2_data     = 8'h77;
        ps2_data_clk = 1'b1;
        chk("irq_before_flush", {15'h0, kbd_irq}, 16'h0001);
        @(negedge clk);
        port_clk     = 1'b0;
        ps2_data_clk = 1'b0;
        model_clear();
        chk("irq_after_flush", {15'h0, kbd_irq}, 16'h0000);
        chk("ovf_after_flush", {15'h0, overflow}, 16'h0000);
        check_stat("stat_flush");
        pop_byte("pop_after_flush");

        // Reset mid-burst with the strobe held high
        for (int i = 0; i < 4; i++) push_byte(8'h90 + 8'(i), 1);
        check_stat("stat_pre_reset");
        @(negedge clk);
        ps2_data     = 8'h55;
        ps2_data_clk = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_port_in", {8'h00, port_in}, 16'h0000);
        chk("mid_rst_irq", {15'h0, kbd_irq}, 16'h0000);
        chk("mid_rst_ovf", {15'h0, overflow}, 16'h0000);
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_push_on_release", {15'h0, kbd_irq}, 16'h0000);
        check_stat("stat_after_release");
        ps2_data_clk = 1'b0;
        @(negedge clk);
        push_byte(8'h3A, 1);
        check_stat("stat_new_push");
        pop_byte("pop_new_push");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
